// File: rtl/bus_arbiter_pkg.sv
// Shared bus arbiter definitions: FSM encodings, requester indices and counter widths.
// Used by bus_arbiter and bus_arb_pick.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_DC  = 0;
  localparam int unsigned REQ_IC  = 1;
  localparam int unsigned REQ_DMA = 2;
  localparam int unsigned REQ_MEM = 3;

  localparam int unsigned HOLD_CNT_W = 8;
  localparam int unsigned TURN_CNT_W = 2;
  localparam int unsigned OWNER_W    = 2;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection for the bus arbiter.
// BUS_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] eligible,
`ifdef BUS_ARB_ROUND_ROBIN_EN
  input  logic [OWNER_W-1:0] rr_ptr,
`endif
  output logic [NUM_REQ-1:0] win_oh_c,
  output logic [OWNER_W-1:0] win_idx_c
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [2*NUM_REQ-1:0] dbl_c;
  logic [NUM_REQ-1:0]   rot_c;
  int unsigned          start_c;
  int unsigned          k_c;

  // Rotate so the search starts after the last owner, encode, then unrotate.
  always_comb begin
    start_c   = (int'(rr_ptr) + 1) % NUM_REQ;
    dbl_c     = {eligible, eligible} >> start_c;
    rot_c     = dbl_c[NUM_REQ-1:0];
    k_c       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_c[i]) k_c = i;
    end
    win_idx_c = OWNER_W'((start_c + k_c) % NUM_REQ);
    win_oh_c  = '0;
    if (|eligible) win_oh_c = NUM_REQ'(1) << win_idx_c;
  end
`else
  // Plain priority encoder, index 0 highest.
  always_comb begin
    win_idx_c = '0;
    win_oh_c  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx_c = OWNER_W'(i);
        win_oh_c  = NUM_REQ'(1) << i;
      end
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Shared system bus arbiter: one-hot grants, tenure hold, turnaround gap, hold watchdog.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic               BUS_CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] BR,
  output logic [NUM_REQ-1:0] BG,
  output logic               BUS_BUSY,
  output logic [OWNER_W-1:0] OWNER,
  output logic               TIMEOUT
);

  arb_state_t             state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [TURN_CNT_W-1:0]  turn_cnt;
  logic [NUM_REQ-1:0]     lockout;
  logic [NUM_REQ-1:0]     eligible_c;
  logic [NUM_REQ-1:0]     win_oh_c;
  logic [OWNER_W-1:0]     win_idx_c;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [OWNER_W-1:0]     rr_ptr;
`endif

  assign eligible_c = BR & ~lockout;

  bus_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible  (eligible_c),
`ifdef BUS_ARB_ROUND_ROBIN_EN
    .rr_ptr    (rr_ptr),
`endif
    .win_oh_c  (win_oh_c),
    .win_idx_c (win_idx_c)
  );

  // Arbitration FSM with registered grant, busy, owner and timeout outputs.
  always_ff @(posedge BUS_CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      BG       <= '0;
      BUS_BUSY <= 1'b0;
      OWNER    <= '0;
      TIMEOUT  <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      lockout  <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      rr_ptr   <= OWNER_W'(NUM_REQ - 1);
`endif
    end else begin
      TIMEOUT <= 1'b0;
      lockout <= lockout & BR;
      case (state)
        ST_IDLE: begin
          if (|eligible_c) begin
            BG       <= win_oh_c;
            OWNER    <= win_idx_c;
            hold_cnt <= '0;
            BUS_BUSY <= 1'b1;
            state    <= ST_HOLD;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rr_ptr   <= win_idx_c;
`endif
          end
        end
        ST_HOLD: begin
          // A release on the watchdog cycle takes precedence over the revoke.
          if (!BR[OWNER]) begin
            BG       <= '0;
            turn_cnt <= '0;
            state    <= ST_TURN;
          end else if (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1)) begin
            BG       <= '0;
            lockout  <= (lockout & BR) | (NUM_REQ'(1) << OWNER);
            TIMEOUT  <= 1'b1;
            turn_cnt <= '0;
            state    <= ST_TURN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_TURN: begin
          if (turn_cnt == TURN_CNT_W'(TURN_CYC - 1)) begin
            BUS_BUSY <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        default: begin
          BG       <= '0;
          BUS_BUSY <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD=8, TURN_CYC=1).
// Contention expectations follow BUS_ARB_ROUND_ROBIN_EN when it is defined.
module tb_bus_arbiter;

  logic       BUS_CLK;
  logic       RST;
  logic [3:0] BR;
  logic [3:0] BG;
  logic       BUS_BUSY;
  logic [1:0] OWNER;
  logic       TIMEOUT;

  int n_checks = 0;
  int n_fails  = 0;

  bus_arbiter #(
    .NUM_REQ  (4),
    .TURN_CYC (1),
    .MAX_HOLD (8)
  ) dut (
    .BUS_CLK  (BUS_CLK),
    .RST      (RST),
    .BR       (BR),
    .BG       (BG),
    .BUS_BUSY (BUS_BUSY),
    .OWNER    (OWNER),
    .TIMEOUT  (TIMEOUT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [3:0] bg, input logic busy,
                           input logic [1:0] own, input logic tmo);
    check({tag, ".bg"},      8'(BG),       8'(bg));
    check({tag, ".busy"},    8'(BUS_BUSY), 8'(busy));
    check({tag, ".owner"},   8'(OWNER),    8'(own));
    check({tag, ".timeout"}, 8'(TIMEOUT),  8'(tmo));
  endtask

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

  initial begin
    RST = 1'b1;
    BR  = 4'b0000;
    repeat (2) @(posedge BUS_CLK);
    #1;
    check_bus("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    RST = 1'b0;
    tick();
    check_bus("idle_after_reset", 4'b0000, 1'b0, 2'd0, 1'b0);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Round robin: all four requesting, each owner releases after 3 cycles.
    BR = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_bus("rr_grant", 4'b0001 << rr_order[g], 1'b1, rr_order[g], 1'b0);
      tick();
      tick();
      check("rr_hold.bg", 8'(BG), 8'(4'b0001 << rr_order[g]));
      BR = 4'b1111 & ~(4'b0001 << rr_order[g]);
      tick();
      check_bus("rr_turn", 4'b0000, 1'b1, rr_order[g], 1'b0);
      BR = 4'b1111;
      tick();
      check_bus("rr_gap", 4'b0000, 1'b0, rr_order[g], 1'b0);
    end
    BR = 4'b0000;
    tick();
    tick();
    tick();
`else
    // Fixed priority contention: lowest index wins.
    BR = 4'b1011;
    tick();
    check_bus("fp_grant0", 4'b0001, 1'b1, 2'd0, 1'b0);
    BR = 4'b1010;
    tick();
    check_bus("fp_turn0", 4'b0000, 1'b1, 2'd0, 1'b0);
    tick();
    check_bus("fp_gap0", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_bus("fp_grant1", 4'b0010, 1'b1, 2'd1, 1'b0);
    BR = 4'b1000;
    tick();
    check_bus("fp_turn1", 4'b0000, 1'b1, 2'd1, 1'b0);
    tick();
    tick();
    check_bus("fp_grant3", 4'b1000, 1'b1, 2'd3, 1'b0);
    BR = 4'b0000;
    tick();
    tick();
    check_bus("fp_idle", 4'b0000, 1'b0, 2'd3, 1'b0);
`endif

    // Watchdog: BR[1] held, BR[3] pending.
    BR = 4'b1010;
    tick();
    check_bus("wd_grant", 4'b0010, 1'b1, 2'd1, 1'b0);
    repeat (7) tick();
    check_bus("wd_last_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
    tick();
    check_bus("wd_revoke", 4'b0000, 1'b1, 2'd1, 1'b1);
    tick();
    check_bus("wd_pulse_end", 4'b0000, 1'b0, 2'd1, 1'b0);
    tick();
    check_bus("wd_next_owner", 4'b1000, 1'b1, 2'd3, 1'b0);
    BR = 4'b0010;
    tick();
    tick();
    tick();
    check_bus("wd_locked_out", 4'b0000, 1'b0, 2'd3, 1'b0);
    BR = 4'b0000;
    tick();
    BR = 4'b0010;
    tick();
    check_bus("wd_unlocked", 4'b0010, 1'b1, 2'd1, 1'b0);
    BR = 4'b0000;
    tick();
    tick();

    // Release on exactly the watchdog cycle: no timeout, no lockout.
    BR = 4'b0001;
    tick();
    check_bus("rel_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    repeat (7) tick();
    check("rel_last_hold.bg", 8'(BG), 8'h01);
    BR = 4'b0000;
    tick();
    check_bus("rel_drop", 4'b0000, 1'b1, 2'd0, 1'b0);
    BR = 4'b0001;
    tick();
    check_bus("rel_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
    tick();
    check_bus("rel_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);
    BR = 4'b0000;
    tick();
    tick();

    // Single request with a 4-cycle tenure.
    BR = 4'b0100;
    tick();
    check_bus("single_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    repeat (3) tick();
    check_bus("single_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    BR = 4'b0000;
    tick();
    check_bus("single_drop", 4'b0000, 1'b1, 2'd2, 1'b0);
    tick();
    check_bus("single_idle", 4'b0000, 1'b0, 2'd2, 1'b0);

    // Asynchronous reset in the middle of a tenure.
    BR = 4'b0100;
    tick();
    check("ar_grant.bg", 8'(BG), 8'h04);
    #2 RST = 1'b1;
    #1;
    check_bus("ar_async", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(posedge BUS_CLK);
    #1 RST = 1'b0;
    tick();
    check_bus("ar_regrant", 4'b0100, 1'b1, 2'd2, 1'b0);
    BR = 4'b0000;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
